// File: rtl/ps2_frame_rx_if.sv
//------------------------------------------------------------------------------
// Module   : ps2_frame_rx_if
// Brief    : PS/2 line inputs and decoded keycode/strobe outputs
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ps2_frame_rx_if;
  logic        kclk;
  logic        kdata;
  logic [15:0] keycode;
  logic        oflag;
  logic        perr;
  logic        ferr;

  modport master (
    output kclk,
    output kdata,
    input  keycode,
    input  oflag,
    input  perr,
    input  ferr
  );

  modport slave (
    input  kclk,
    input  kdata,
    output keycode,
    output oflag,
    output perr,
    output ferr
  );
endinterface

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
//------------------------------------------------------------------------------
// Module   : ps2_frame_rx
// Brief    : PS/2 device-to-host frame receiver with glitch filter, parity,
//            stop-bit and inter-bit timeout checking
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_frame_rx_if.slave  ps2
);

  localparam int c_TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic       w_kclk;
  logic       w_kdata;
  logic       w_fall;
  logic       w_expire;

  assign w_raw = {ps2.kdata, ps2.kclk};

  // Channel 0 conditions kclk, channel 1 conditions kdata; both idle high.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_cond
      logic       sync1_q;
      logic       sync2_q;
      logic       filt_q;
      logic [7:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          filt_q  <= 1'b1;
          cnt_q   <= 8'd0;
        end else begin
          sync1_q <= w_raw[g];
          sync2_q <= sync1_q;
          if (sync2_q == filt_q) begin
            cnt_q <= 8'd0;
          end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
            filt_q <= ~filt_q;
            cnt_q  <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      end

      assign w_filt[g] = filt_q;
    end
  endgenerate

  assign w_kclk  = w_filt[0];
  assign w_kdata = w_filt[1];

  state_t                state_q,   state_d;
  logic                  kclk_prev_q;
  logic [2:0]            bitcnt_q,  bitcnt_d;
  logic [7:0]            shift_q,   shift_d;
  logic                  par_q,     par_d;
  logic [c_TCNT_W-1:0]   tcnt_q,    tcnt_d;
  logic [15:0]           keycode_q, keycode_d;
  logic                  oflag_q,   oflag_d;
  logic                  perr_q,    perr_d;
  logic                  ferr_q,    ferr_d;

  assign w_fall   = kclk_prev_q & ~w_kclk;
  // A falling edge on the expiry cycle wins, so expiry requires no edge.
  assign w_expire = (state_q != S_IDLE) && !w_fall &&
                    (tcnt_q == c_TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      kclk_prev_q <= 1'b1;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      keycode_q   <= 16'h0000;
      oflag_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kclk_prev_q <= w_kclk;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      keycode_q   <= keycode_d;
      oflag_q     <= oflag_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    keycode_d = keycode_q;
    oflag_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (w_fall || state_q == S_IDLE) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + c_TCNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (w_fall && !w_kdata) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
          shift_d  = 8'd0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          shift_d  = {w_kdata, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          par_d   = w_kdata;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          state_d = S_IDLE;
          if (!w_kdata) begin
            ferr_d = 1'b1;
          end else if (^{shift_q, par_q} != 1'b1) begin
            perr_d = 1'b1;
          end else begin
            oflag_d   = 1'b1;
            keycode_d = {keycode_q[7:0], shift_q};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_expire) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end
  end

  assign ps2.keycode = keycode_q;
  assign ps2.oflag   = oflag_q;
  assign ps2.perr    = perr_q;
  assign ps2.ferr    = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_frame_rx
// Brief    : Randomized frame-level bench for ps2_frame_rx with event model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_frame_rx;

  localparam int FL = 4;
  localparam int TO = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_frame_rx_if bus ();

  ps2_frame_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps2   (bus)
  );

  // kind: 0 = accepted byte, 1 = parity error, 2 = framing error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t         q[$];
  logic [15:0] exp_kc = 16'h0000;
  ev_t         ce;
  logic [2:0]  cs;
  logic [2:0]  cwant;

  always @(negedge clk) begin
    if (rst_n) begin
      cs = {bus.ferr, bus.perr, bus.oflag};
      if (cs != 3'b000) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: ferr/perr/oflag=%b at cycle %0d, required none", cs, cyc);
        end else begin
          ce    = q.pop_front();
          cwant = 3'b001 << ce.kind;
          if (cs !== cwant || cyc < ce.lo || cyc > ce.hi) begin
            errors++;
            $display("FAIL strobe_event: ferr/perr/oflag=%b at cycle %0d, required %b in cycles %0d..%0d",
                     cs, cyc, cwant, ce.lo, ce.hi);
          end
          if (ce.kind == 0) exp_kc = {exp_kc[7:0], ce.data};
        end
      end
      vectors++;
      if (bus.keycode !== exp_kc) begin
        errors++;
        $display("FAIL keycode: got %h at cycle %0d, required %h", bus.keycode, cyc, exp_kc);
      end
    end
  end

  task automatic check_kc(input string name, input logic [15:0] want);
    vectors++;
    if (bus.keycode !== want) begin
      errors++;
      $display("FAIL %s: keycode got %h, required %h", name, bus.keycode, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus.keycode !== 16'h0000 || {bus.oflag, bus.perr, bus.ferr} !== 3'b000) begin
      errors++;
      $display("FAIL %s: keycode=%h oflag/perr/ferr=%b, required 0000 and 000",
               name, bus.keycode, {bus.oflag, bus.perr, bus.ferr});
    end
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL strobe_missing: %0d events still pending, required 0", q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // nafter = bits sent after the start bit (10 = full frame).
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nafter, input bit glitch, input bit abort, input int hfix);
    logic [10:0] fr;
    int          h;
    int          nb;
    int          fc;
    ev_t         e;
    h  = (hfix > 0) ? hfix : $urandom_range(10, 30);
    fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    nb = (nafter >= 10) ? 11 : nafter + 1;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.kdata = fr[i];
      if (glitch && i == 4) begin
        repeat (2) @(negedge clk);
        bus.kclk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        bus.kclk = 1'b1;
      end
      repeat (h) @(negedge clk);
      bus.kclk = 1'b0;
      fc = cyc;
      if (i == nb - 1) begin
        if (abort) return;
        e.data = d;
        if (nb == 11) begin
          e.kind = bad_stop ? 2 : (bad_par ? 1 : 0);
          e.lo   = fc + FL + 3;
          e.hi   = e.lo;
        end else begin
          e.kind = 2;
          e.lo   = fc + TO;
          e.hi   = fc + TO + FL + 10;
        end
        q.push_back(e);
      end
      repeat (h) @(negedge clk);
      bus.kclk = 1'b1;
    end
    @(negedge clk);
    bus.kdata = 1'b1;
  endtask

  task automatic idle_pulse();
    @(negedge clk);
    bus.kdata = 1'b1;
    repeat (12) @(negedge clk);
    bus.kclk = 1'b0;
    repeat (12) @(negedge clk);
    bus.kclk = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_kc = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    bus.kclk  = 1'b1;
    bus.kdata = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("first_1c", 16'h001C);

    reset_pulse();
    send_frame(8'hF0, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("make_f0", 16'h00F0);
    send_frame(8'h1C, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("f0_then_1c", 16'hF01C);

    send_frame(8'h1C, 1, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("parity_err_hold", 16'hF01C);
    send_frame(8'h32, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("after_perr_32", 16'h1C32);

    send_frame(8'h77, 0, 1, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("stop_err_hold", 16'h1C32);

    send_frame(8'hAA, 0, 0, 5, 0, 0, 15);
    wait_drain(TO + 100);
    check_kc("timeout_hold", 16'h1C32);
    send_frame(8'h1C, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("after_timeout_1c", 16'h321C);

    send_frame(8'h5A, 0, 0, 10, 1, 0, 15);
    wait_drain(100);
    check_kc("glitch_5a", 16'h1C5A);

    send_frame(8'hA5, 0, 0, 3, 0, 1, 15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    bus.kclk  = 1'b1;
    bus.kdata = 1'b1;
    q.delete();
    exp_kc = 16'h0000;
    repeat (20) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 0, 0, 10, 0, 0, 15);
    wait_drain(100);
    check_kc("after_reset_1c", 16'h001C);

    for (int n = 0; n < 36; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 12)
        send_frame(8'($urandom), 0, 0, 10, ($urandom_range(0, 3) == 0), 0, 0);
      else if (r <= 15)
        send_frame(8'($urandom), 1, 0, 10, 0, 0, 0);
      else if (r <= 17)
        send_frame(8'($urandom), $urandom_range(0, 1), 1, 10, 0, 0, 0);
      else if (r == 18)
        send_frame(8'($urandom), 0, 0, $urandom_range(0, 9), 0, 0, 0);
      else
        idle_pulse();
      wait_drain(TO + 100);
      repeat ($urandom_range(2, 30)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
